// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32I pipeline: forwarding, load-use,
// memory-wait FSM with watchdog, redirect qualification. Optional perf counters: HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rs1E,
  input  logic [4:0] rs2E,
  input  logic [4:0] rdE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic [1:0] wbselE,
  input  logic       pcselE,
  input  logic       memreqM,
  input  logic       mem_readyM,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushW,
  output logic       pc_redirect,
  output logic       mem_timeout,
  output logic       busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [15:0] perf_timeout_cnt
`endif
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] waitCnt, waitCntNext;
  logic             memStall, stallMem, timeoutHit, loadUse, loadUseEff;

  assign memStall = memreqM && !mem_readyM;

  // A dropped memreqM while waiting counts as completion, so !memStall covers both exits.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    stallMem    = 1'b0;
    timeoutHit  = 1'b0;
    case (state)
      RUN: begin
        if (memStall) begin
          stallMem    = 1'b1;
          stateNext   = MEMWAIT;
          waitCntNext = CNT_W'(1);
        end
      end
      MEMWAIT: begin
        if (!memStall) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (waitCnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          timeoutHit  = 1'b1;
          stateNext   = RUN;
          waitCntNext = '0;
        end else begin
          stallMem    = 1'b1;
          waitCntNext = waitCnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext   = RUN;
        waitCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regwriteM && rdM != 5'd0 && rdM == rs1E)      forwardAE = 2'b10;
    else if (regwriteW && rdW != 5'd0 && rdW == rs1E) forwardAE = 2'b01;
    if (regwriteM && rdM != 5'd0 && rdM == rs2E)      forwardBE = 2'b10;
    else if (regwriteW && rdW != 5'd0 && rdW == rs2E) forwardBE = 2'b01;
  end

  // Load-use is also evaluated on the release cycle, where the pipeline advances again.
  assign loadUse     = regwriteE && wbselE == 2'b00 && rdE != 5'd0 &&
                       (rdE == rs1D || rdE == rs2D);
  assign pc_redirect = pcselE && !stallMem;
  assign loadUseEff  = loadUse && !stallMem && !pc_redirect;

  assign stallF      = stallMem || loadUseEff;
  assign stallD      = stallMem || loadUseEff;
  assign stallE      = stallMem;
  assign stallM      = stallMem;
  assign flushD      = pc_redirect;
  assign flushE      = pc_redirect || loadUseEff;
  assign mem_timeout = timeoutHit && !rst;
  assign flushW      = stallMem || mem_timeout;
  assign busy        = (state == MEMWAIT);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt   <= '0;
      perf_flush_cnt   <= '0;
      perf_timeout_cnt <= '0;
    end else begin
      if (stallF && perf_stall_cnt != '1)        perf_stall_cnt   <= perf_stall_cnt + 32'd1;
      if (pc_redirect && perf_flush_cnt != '1)   perf_flush_cnt   <= perf_flush_cnt + 32'd1;
      if (mem_timeout && perf_timeout_cnt != '1) perf_timeout_cnt <= perf_timeout_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic, all checked
// against a cycle-count reference model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteE, regwriteM, regwriteW;
  logic [1:0] wbselE;
  logic       pcselE, memreqM, mem_readyM;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic       pc_redirect, mem_timeout, busy;

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .wbselE(wbselE), .pcselE(pcselE), .memreqM(memreqM), .mem_readyM(mem_readyM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .pc_redirect(pc_redirect), .mem_timeout(mem_timeout), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Model state: number of cycles the current memory access has been stalled (0 = running).
  int waitCycles = 0;
  int nextWait   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwdSel(input logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Settle after inputs change, then compare the full output bundle with the model.
  task automatic eval(input string tag);
    bit ms, hold, tmo, redir, lu;
    logic [13:0] exp, act;
    #1;
    ms = memreqM && !mem_readyM;
    if (waitCycles == 0) begin
      hold = ms;
      tmo  = 0;
    end else begin
      hold = ms && (waitCycles < TMO - 1);
      tmo  = ms && (waitCycles == TMO - 1);
    end
    nextWait = hold ? waitCycles + 1 : 0;
    if (rst) begin
      tmo      = 0;
      nextWait = 0;
    end
    redir = pcselE && !hold;
    lu    = regwriteE && wbselE == 2'b00 && rdE != 0 && (rdE == rs1D || rdE == rs2D)
            && !hold && !redir;
    exp = {fwdSel(rs1E), fwdSel(rs2E), hold | lu, hold | lu, hold, hold,
           redir, redir | lu, hold | tmo, redir, tmo, waitCycles != 0};
    act = {forwardAE, forwardBE, stallF, stallD, stallE, stallM,
           flushD, flushE, flushW, pc_redirect, mem_timeout, busy};
    check(tag, 32'(act), 32'(exp));
  endtask

  task automatic adv();
    @(posedge clk);
    waitCycles = nextWait;
    #1;
  endtask

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; wbselE = 2'b01;
    pcselE = 0; memreqM = 0; mem_readyM = 0;
  endtask

  initial begin
    bit slow;
    idle();
    rst = 1;
    @(posedge clk); #1;
    eval("reset");
    check("reset_stallF", 32'(stallF), 0);
    check("reset_busy", 32'(busy), 0);
    adv();
    rst = 0;

    // load-use: one bubble, then the load has moved on to M
    rdE = 5; wbselE = 2'b00; regwriteE = 1; rs1D = 5;
    eval("lu");
    check("lu_stall", 32'({stallF, stallD, flushE}), 32'h7);
    adv();
    regwriteE = 0; rdE = 0; rdM = 5; regwriteM = 1; wbselE = 2'b01;
    eval("lu_after");
    check("lu_clear", 32'({stallF, stallD, flushE}), 0);
    adv();

    // forwarding priority
    idle();
    rdM = 3; regwriteM = 1; rdW = 3; regwriteW = 1; rs1E = 3; rs2E = 0;
    eval("fwd_m");
    check("fwdA_m", 32'(forwardAE), 2);
    check("fwdB_zero", 32'(forwardBE), 0);
    adv();
    rdM = 0;
    eval("fwd_w");
    check("fwdA_w", 32'(forwardAE), 1);
    adv();

    // memory wait, four stalled cycles then ready
    idle();
    memreqM = 1; mem_readyM = 0;
    for (int i = 0; i < 4; i++) begin
      eval("mw_stall");
      check("mw_stallM", 32'({stallF, stallE, stallM, flushW}), 32'hF);
      if (i > 0) check("mw_busy", 32'(busy), 1);
      check("mw_no_tmo", 32'(mem_timeout), 0);
      adv();
    end
    mem_readyM = 1;
    eval("mw_release");
    check("mw_release", 32'({stallF, stallM, flushW, mem_timeout}), 0);
    adv();
    idle();
    eval("mw_idle");
    check("mw_busy_off", 32'(busy), 0);
    adv();

    // watchdog expiry
    memreqM = 1; mem_readyM = 0;
    for (int i = 1; i <= 16; i++) begin
      eval("tmo_seq");
      check("tmo_pulse", 32'(mem_timeout), 32'(i == 16));
      adv();
    end
    idle();
    eval("tmo_after");
    check("tmo_busy_off", 32'(busy), 0);
    adv();

    // branch held during a memory stall redirects once on release
    pcselE = 1; memreqM = 1; mem_readyM = 0;
    for (int i = 0; i < 3; i++) begin
      eval("br_hold");
      check("br_no_redir", 32'(pc_redirect), 0);
      adv();
    end
    mem_readyM = 1;
    eval("br_release");
    check("br_redir", 32'({pc_redirect, flushD, flushE}), 32'h7);
    adv();
    idle();
    eval("br_once");
    check("br_single", 32'(pc_redirect), 0);
    adv();

    // reset during MEMWAIT, then counter restarts
    memreqM = 1; mem_readyM = 0;
    eval("rw_c1"); adv();
    eval("rw_c2"); adv();
    rst = 1;
    eval("rw_rst");
    check("rw_rst_tmo", 32'(mem_timeout), 0);
    adv();
    rst = 0;
    for (int i = 1; i <= 16; i++) begin
      eval("rw_seq");
      if (i == 1) check("rw_busy_off", 32'(busy), 0);
      check("rw_tmo", 32'(mem_timeout), 32'(i == 16));
      adv();
    end

    // randomized traffic, alternating fast and slow memory phases
    slow = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) slow = ~slow;
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
      rdW  = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      wbselE = 2'($urandom_range(0, 2));
      pcselE = ($urandom_range(0, 3) == 0);
      if (slow) begin
        memreqM    = ($urandom_range(0, 19) != 0);
        mem_readyM = ($urandom_range(0, 24) == 0);
      end else begin
        memreqM    = ($urandom_range(0, 2) == 0);
        mem_readyM = 1'($urandom);
      end
      rst = ($urandom_range(0, 149) == 0);
      eval("rand");
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core (F/D/E/M/W).
- Generates the forwarding selects, stall/flush enables for every pipeline register, and the PC-redirect qualifier.
- Sequences multi-cycle data-memory accesses with a wait FSM and a timeout watchdog.
- Sits beside the datapath; decode consumes flushE, fetch consumes stallF/pc_redirect.

Parameters:
- MEM_TIMEOUT, 16, max cycles held in MEMWAIT before forced release (≥2)
- CNT_W, 5, width of wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- rs1D, rs2D  in  5  source regs of instruction in D
- rs1E, rs2E  in  5  source regs of instruction in E
- rdE, rdM, rdW  in  5  destination regs in E/M/W
- regwriteE, regwriteM, regwriteW  in  1  write-enable in E/M/W
- wbselE  in  2  writeback select in E (00=load, 01=ALU, 10=PC+4)
- pcselE  in  1  branch taken or jump resolved in E
- memreqM  in  1  M-stage instruction accesses data memory
- mem_readyM  in  1  data memory completes access this cycle
- forwardAE, forwardBE  out  2  E operand select: 00 regfile, 01 resultW, 10 ALU result M
- stallF, stallD, stallE, stallM  out  1  hold the respective pipeline register
- flushD, flushE, flushW  out  1  load bubble into the respective register
- pc_redirect  out  1  fetch takes branch/jump target this cycle
- mem_timeout  out  1  one-cycle pulse on watchdog expiry
- busy  out  1  FSM in MEMWAIT

Behaviour:
- Reset: state=RUN, wait counter=0, mem_timeout=0. All stall/flush/redirect outputs evaluate to 0 in reset when inputs are idle.
- Forwarding (combinational):
  - forwardAE=10 if regwriteM && rdM!=0 && rdM==rs1E.
  - Else 01 if regwriteW && rdW!=0 && rdW==rs1E.
  - Else 00. forwardBE is the same using rs2E. M beats W.
- Load-use (combinational, RUN only):
  - lu = regwriteE && wbselE==00 && rdE!=0 && (rdE==rs1D || rdE==rs2D). rs2D is compared for every format (conservative).
  - lu → stallF=stallD=1 and flushE=1 for exactly one cycle. The load then moves to M and lu clears.
- Memory stall, ms = memreqM && !mem_readyM:
  - In RUN: ms → stallF=stallD=stallE=stallM=1, flushW=1 in that same cycle; next state MEMWAIT, counter=1.
  - In MEMWAIT: the same stall outputs hold every cycle. Counter increments each cycle.
  - Exit to RUN when mem_readyM=1; that cycle has no stall and no flushW.
  - Exit when counter==MEM_TIMEOUT-1: mem_timeout=1 that cycle, stalls released, flushW=1 (result discarded). Counter clears to 0.
  - memreqM=0 observed in MEMWAIT is treated as mem_readyM=1.
- Redirect: pc_redirect = pcselE && !stall_mem. When pc_redirect=1, flushD=flushE=1.
  - While stalled, the branch is held in E and redirect occurs on the release cycle; there is no double redirect.
- Priority:
  - Memory stall > redirect > load-use.
  - Redirect and lu together: redirect wins. flushD=flushE=1, stallF=stallD=0.
  - Memory stall with lu: only memory-stall outputs are asserted; lu is re-evaluated on release.
- Reset asserted mid-MEMWAIT: next cycle is RUN with counter=0 and no timeout pulse.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] (cycles with stallF=1), perf_flush_cnt[31:0] (cycles with pc_redirect=1), perf_timeout_cnt[15:0].
  - All counters clear on rst and saturate at all-ones.
- Undefined: ports absent, no counter logic.

Test Plan:
- lw x5 in E (rdE=5, wbselE=00, regwriteE=1), rs1D=5 → one cycle stallF=stallD=flushE=1, then all 0.
- rdM=3/regwriteM=1 and rdW=3/regwriteW=1, rs1E=3 → forwardAE=10. With rdM=0 → 01. rs2E=0 with rdW=0 → forwardBE=00.
- memreqM=1, mem_readyM low 4 cycles then high → stalls high 4 cycles with busy=1, flushW=1 each stalled cycle, release on cycle 5, mem_timeout never pulses.
- mem_readyM never rises, MEM_TIMEOUT=16 → mem_timeout pulses on the 16th stalled cycle, state returns to RUN, busy=0.
- pcselE=1 during a 3-cycle memory stall → pc_redirect=0 for 3 cycles, then exactly one cycle of pc_redirect=1 with flushD=flushE=1.
- rst pulsed on the 2nd MEMWAIT cycle → busy=0 next cycle, counter restarts from 1 on the next ms.
